// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported SRAM between the fetch stage (read-only port) and
// the memory stage (load/store port). Grants one requester at a time, runs a
// fixed-latency SRAM access with the chip enable held for ACCESS_CYCLES
// cycles, then returns a registered one-cycle acknowledge plus the raw word.
// Byte-lane extraction and sign extension stay in the memory stage.
//
// Parameters
//   ACCESS_CYCLES  cycles ram_ce is held before ram_rdata is valid (1..15)
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   inst_req/inst_addr            fetch read request, held until inst_ack
//   inst_ack/inst_rdata           one-cycle ack, fetched word (held)
//   flush                         cancels delivery of an in-flight fetch
//   data_req/we/addr/sel/wdata    memory-stage load/store request
//   data_ack/data_rdata           one-cycle ack, loaded word (held)
//   pause_if/pause_mem            request pending and not yet acknowledged
//   ram_ce/we/addr/sel/wdata      registered SRAM command outputs
//   ram_rdata                     SRAM read data, sampled in the last cycle
//
// Latency: a request sampled in IDLE at cycle N drives ram_ce in cycles
// N+1..N+ACCESS_CYCLES and is acknowledged in cycle N+ACCESS_CYCLES+1.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic [31:0] inst_rdata,
  input  logic        flush,
  // memory-stage port
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  // pipeline stalls
  output logic        pause_if,
  output logic        pause_mem,
  // SRAM
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // The counter is loaded with ACCESS_CYCLES-1 on grant and the access
  // finishes in the BUSY cycle where it reads zero, giving exactly
  // ACCESS_CYCLES cycles of ram_ce.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state_reg, state_next;
  owner_t      owner_reg, owner_next;
  owner_t      last_grant_reg, last_grant_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        cancel_reg, cancel_next;

  logic        ram_ce_reg, ram_ce_next;
  logic        ram_we_reg, ram_we_next;
  logic [31:0] ram_addr_reg, ram_addr_next;
  logic [3:0]  ram_sel_reg, ram_sel_next;
  logic [31:0] ram_wdata_reg, ram_wdata_next;

  logic        inst_ack_reg, inst_ack_next;
  logic        data_ack_reg, data_ack_next;
  logic [31:0] inst_rdata_reg, inst_rdata_next;
  logic [31:0] data_rdata_reg, data_rdata_next;

  logic        inst_elig;
  logic        data_elig;
  logic        grant_inst;
  logic        grant_data;

  // A requester that is being acknowledged this cycle still holds its req
  // high; masking it here keeps the same request from being granted twice.
  assign inst_elig = inst_req & ~inst_ack_reg;
  assign data_elig = data_req & ~data_ack_reg;

  // On a tie the port that did not win last time gets the SRAM.
  always_comb begin
    grant_data = data_elig & (~inst_elig | (last_grant_reg == OWN_INST));
    grant_inst = inst_elig & ~grant_data;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_INST;
      last_grant_reg <= OWN_INST;
      cnt_reg        <= 4'd0;
      cancel_reg     <= 1'b0;
      ram_ce_reg     <= 1'b0;
      ram_we_reg     <= 1'b0;
      ram_addr_reg   <= 32'd0;
      ram_sel_reg    <= 4'd0;
      ram_wdata_reg  <= 32'd0;
      inst_ack_reg   <= 1'b0;
      data_ack_reg   <= 1'b0;
      inst_rdata_reg <= 32'd0;
      data_rdata_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      cancel_reg     <= cancel_next;
      ram_ce_reg     <= ram_ce_next;
      ram_we_reg     <= ram_we_next;
      ram_addr_reg   <= ram_addr_next;
      ram_sel_reg    <= ram_sel_next;
      ram_wdata_reg  <= ram_wdata_next;
      inst_ack_reg   <= inst_ack_next;
      data_ack_reg   <= data_ack_next;
      inst_rdata_reg <= inst_rdata_next;
      data_rdata_reg <= data_rdata_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    cancel_next     = cancel_reg;
    ram_ce_next     = ram_ce_reg;
    ram_we_next     = ram_we_reg;
    ram_addr_next   = ram_addr_reg;
    ram_sel_next    = ram_sel_reg;
    ram_wdata_next  = ram_wdata_reg;
    inst_ack_next   = 1'b0;
    data_ack_next   = 1'b0;
    inst_rdata_next = inst_rdata_reg;
    data_rdata_next = data_rdata_reg;

    unique case (state_reg)
      IDLE: begin
        cancel_next = 1'b0;
        if (grant_inst) begin
          state_next      = BUSY;
          owner_next      = OWN_INST;
          last_grant_next = OWN_INST;
          cnt_next        = CNT_LOAD;
          ram_ce_next     = 1'b1;
          ram_we_next     = 1'b0;
          ram_addr_next   = inst_addr;
          ram_sel_next    = 4'b1111;
          ram_wdata_next  = 32'd0;
          // A flush in the grant cycle already kills this fetch's delivery.
          cancel_next     = flush;
        end else if (grant_data) begin
          state_next      = BUSY;
          owner_next      = OWN_DATA;
          last_grant_next = OWN_DATA;
          cnt_next        = CNT_LOAD;
          ram_ce_next     = 1'b1;
          ram_we_next     = data_we;
          ram_addr_next   = data_addr;
          ram_sel_next    = data_sel;
          ram_wdata_next  = data_wdata;
        end
      end

      BUSY: begin
        // The SRAM access always runs to completion; flush only decides
        // whether a fetch result is handed back.
        if ((owner_reg == OWN_INST) && flush) begin
          cancel_next = 1'b1;
        end
        if (cnt_reg == 4'd0) begin
          state_next  = IDLE;
          ram_ce_next = 1'b0;
          ram_we_next = 1'b0;
          cancel_next = 1'b0;
          if (owner_reg == OWN_INST) begin
            if (!(cancel_reg || flush)) begin
              inst_ack_next   = 1'b1;
              inst_rdata_next = ram_rdata;
            end
          end else begin
            data_ack_next   = 1'b1;
            data_rdata_next = ram_rdata;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign inst_ack   = inst_ack_reg;
  assign inst_rdata = inst_rdata_reg;
  assign data_ack   = data_ack_reg;
  assign data_rdata = data_rdata_reg;

  assign ram_ce    = ram_ce_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_sel   = ram_sel_reg;
  assign ram_wdata = ram_wdata_reg;

  assign pause_if  = inst_req & ~inst_ack_reg;
  assign pause_mem = data_req & ~data_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters (ACCESS_CYCLES = 2 and 1) run side by side under independent
// random fetch/load/store/flush traffic. Each has its own SRAM behind it. A
// transaction-level reference model per instance predicts grants, acks,
// returned words, and SRAM commands from the arbitration rules and a
// reference copy of memory contents.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NCFG = 2;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        inst_req   [NCFG];
  logic [31:0] inst_addr  [NCFG];
  logic        inst_ack   [NCFG];
  logic [31:0] inst_rdata [NCFG];
  logic        flush      [NCFG];
  logic        data_req   [NCFG];
  logic        data_we    [NCFG];
  logic [31:0] data_addr  [NCFG];
  logic [3:0]  data_sel   [NCFG];
  logic [31:0] data_wdata [NCFG];
  logic        data_ack   [NCFG];
  logic [31:0] data_rdata [NCFG];
  logic        pause_if   [NCFG];
  logic        pause_mem  [NCFG];
  logic        ram_ce     [NCFG];
  logic        ram_we     [NCFG];
  logic [31:0] ram_addr   [NCFG];
  logic [3:0]  ram_sel    [NCFG];
  logic [31:0] ram_wdata  [NCFG];
  logic [31:0] ram_rdata  [NCFG];

  logic [31:0] sram    [NCFG][16];
  logic [31:0] ref_mem [NCFG][16];

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_cfg
      mem_port_arbiter #(.ACCESS_CYCLES((gi == 0) ? 2 : 1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req[gi]),
        .inst_addr  (inst_addr[gi]),
        .inst_ack   (inst_ack[gi]),
        .inst_rdata (inst_rdata[gi]),
        .flush      (flush[gi]),
        .data_req   (data_req[gi]),
        .data_we    (data_we[gi]),
        .data_addr  (data_addr[gi]),
        .data_sel   (data_sel[gi]),
        .data_wdata (data_wdata[gi]),
        .data_ack   (data_ack[gi]),
        .data_rdata (data_rdata[gi]),
        .pause_if   (pause_if[gi]),
        .pause_mem  (pause_mem[gi]),
        .ram_ce     (ram_ce[gi]),
        .ram_we     (ram_we[gi]),
        .ram_addr   (ram_addr[gi]),
        .ram_sel    (ram_sel[gi]),
        .ram_wdata  (ram_wdata[gi]),
        .ram_rdata  (ram_rdata[gi])
      );
      assign ram_rdata[gi] = sram[gi][ram_addr[gi][5:2]];
    end
  endgenerate

  // ---------------- reference model state ----------------
  int          m_left      [NCFG];  // SRAM cycles still to run, 0 = idle
  bit          m_is_inst   [NCFG];
  logic [31:0] m_addr      [NCFG];
  logic        m_we        [NCFG];
  logic [3:0]  m_sel       [NCFG];
  logic [31:0] m_wdata     [NCFG];
  bit          m_cancel    [NCFG];
  bit          m_last_data [NCFG];  // 1 when the previous grant went to data
  // expected registered outputs for the current cycle
  logic        e_iack   [NCFG];
  logic        e_dack   [NCFG];
  logic        e_dload  [NCFG];
  logic [31:0] e_irdata [NCFG];
  logic [31:0] e_drdata [NCFG];
  logic [31:0] e_addr   [NCFG];
  logic [3:0]  e_sel    [NCFG];
  logic [31:0] e_wdata  [NCFG];
  // SRAM command seen last cycle (written into the SRAM at the edge)
  logic        p_ce    [NCFG];
  logic        p_we    [NCFG];
  logic [31:0] p_addr  [NCFG];
  logic [3:0]  p_sel   [NCFG];
  logic [31:0] p_wdata [NCFG];
  bit          flush_prev [NCFG];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ac_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic model_reset(input int k);
    m_left[k]      = 0;
    m_is_inst[k]   = 1'b0;
    m_addr[k]      = 32'd0;
    m_we[k]        = 1'b0;
    m_sel[k]       = 4'd0;
    m_wdata[k]     = 32'd0;
    m_cancel[k]    = 1'b0;
    m_last_data[k] = 1'b0;
    e_iack[k]      = 1'b0;
    e_dack[k]      = 1'b0;
    e_dload[k]     = 1'b0;
    e_irdata[k]    = 32'd0;
    e_drdata[k]    = 32'd0;
    e_addr[k]      = 32'd0;
    e_sel[k]       = 4'd0;
    e_wdata[k]     = 32'd0;
    p_ce[k]        = 1'b0;
    p_we[k]        = 1'b0;
    p_addr[k]      = 32'd0;
    p_sel[k]       = 4'd0;
    p_wdata[k]     = 32'd0;
    flush_prev[k]  = 1'b0;
  endtask

  // Advance the model across the coming clock edge using the inputs that
  // are currently applied.
  task automatic model_step(input int k);
    logic n_iack, n_dack, ie, de, take_data;
    logic [3:0] idx;
    n_iack = 1'b0;
    n_dack = 1'b0;
    if (m_left[k] > 0) begin
      if (m_is_inst[k] && flush[k]) m_cancel[k] = 1'b1;
      if (m_left[k] == 1) begin
        idx = m_addr[k][5:2];
        if (m_is_inst[k]) begin
          if (!m_cancel[k]) begin
            n_iack      = 1'b1;
            e_irdata[k] = ref_mem[k][idx];
          end
        end else begin
          n_dack     = 1'b1;
          e_dload[k] = !m_we[k];
          if (m_we[k]) ref_mem[k][idx] = merge_bytes(ref_mem[k][idx], m_wdata[k], m_sel[k]);
          else         e_drdata[k] = ref_mem[k][idx];
        end
        m_cancel[k] = 1'b0;
      end
      m_left[k]--;
    end else begin
      ie = inst_req[k] && !e_iack[k];
      de = data_req[k] && !e_dack[k];
      if (ie || de) begin
        take_data      = de && (!ie || !m_last_data[k]);
        m_last_data[k] = take_data;
        m_is_inst[k]   = !take_data;
        m_left[k]      = ac_of(k);
        m_cancel[k]    = !take_data && flush[k];
        if (take_data) begin
          m_addr[k]  = data_addr[k];
          m_we[k]    = data_we[k];
          m_sel[k]   = data_sel[k];
          m_wdata[k] = data_wdata[k];
        end else begin
          m_addr[k]  = inst_addr[k];
          m_we[k]    = 1'b0;
          m_sel[k]   = 4'b1111;
          m_wdata[k] = 32'd0;
        end
        e_addr[k]  = m_addr[k];
        e_sel[k]   = m_sel[k];
        e_wdata[k] = m_wdata[k];
      end
    end
    e_iack[k] = n_iack;
    e_dack[k] = n_dack;
  endtask

  task automatic check_regs(input int k);
    string c;
    c = $sformatf("c%0d_", k);
    check_val({c, "inst_ack"},   32'(inst_ack[k]), 32'(e_iack[k]));
    check_val({c, "data_ack"},   32'(data_ack[k]), 32'(e_dack[k]));
    check_val({c, "inst_rdata"}, inst_rdata[k], e_irdata[k]);
    if (e_dack[k] && e_dload[k]) check_val({c, "data_rdata"}, data_rdata[k], e_drdata[k]);
    check_val({c, "ram_ce"},     32'(ram_ce[k]), 32'(m_left[k] > 0));
    check_val({c, "ram_we"},     32'(ram_we[k]), 32'((m_left[k] > 0) && m_we[k]));
    check_val({c, "ram_addr"},   ram_addr[k], e_addr[k]);
    check_val({c, "ram_sel"},    32'(ram_sel[k]), 32'(e_sel[k]));
    check_val({c, "ram_wdata"},  ram_wdata[k], e_wdata[k]);
    if (inst_ack[k]) $display("c%0d t=%0t inst ack addr-word=%0d rdata=0x%08h", k, $time,
                              ram_addr[k][5:2], inst_rdata[k]);
    if (data_ack[k]) $display("c%0d t=%0t data ack rdata=0x%08h", k, $time, data_rdata[k]);
  endtask

  task automatic check_zero(input int k, input string tag);
    string c;
    c = $sformatf("c%0d_%s_", k, tag);
    check_val({c, "ram_ce"},     32'(ram_ce[k]), 32'd0);
    check_val({c, "ram_we"},     32'(ram_we[k]), 32'd0);
    check_val({c, "ram_addr"},   ram_addr[k], 32'd0);
    check_val({c, "ram_sel"},    32'(ram_sel[k]), 32'd0);
    check_val({c, "ram_wdata"},  ram_wdata[k], 32'd0);
    check_val({c, "inst_ack"},   32'(inst_ack[k]), 32'd0);
    check_val({c, "data_ack"},   32'(data_ack[k]), 32'd0);
    check_val({c, "inst_rdata"}, inst_rdata[k], 32'd0);
    check_val({c, "data_rdata"}, data_rdata[k], 32'd0);
    check_val({c, "pause_if"},   32'(pause_if[k]), 32'(inst_req[k]));
    check_val({c, "pause_mem"},  32'(pause_mem[k]), 32'(data_req[k]));
  endtask

  task automatic clear_inputs(input int k);
    inst_req[k]   = 1'b0;
    inst_addr[k]  = 32'd0;
    flush[k]      = 1'b0;
    data_req[k]   = 1'b0;
    data_we[k]    = 1'b0;
    data_addr[k]  = 32'd0;
    data_sel[k]   = 4'd0;
    data_wdata[k] = 32'd0;
  endtask

  task automatic new_inst(input int k);
    inst_req[k]  = 1'b1;
    inst_addr[k] = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic new_data(input int k);
    data_req[k]   = 1'b1;
    data_we[k]    = 1'($urandom_range(0, 1));
    data_addr[k]  = $urandom();
    data_sel[k]   = data_we[k] ? 4'($urandom_range(1, 15)) : 4'hF;
    data_wdata[k] = $urandom();
  endtask

  // Requesters hold req until ack; a flushed fetch is abandoned next cycle.
  task automatic drive(input int k, input bit force_both);
    bit abandon;
    abandon       = flush_prev[k];
    flush[k]      = force_both ? 1'b0 : ($urandom_range(0, 9) == 0);
    flush_prev[k] = flush[k];
    if (force_both) new_inst(k);
    else if (inst_req[k] && (inst_ack[k] || abandon)) begin
      if ($urandom_range(0, 1) == 1) new_inst(k);
      else inst_req[k] = 1'b0;
    end else if (!inst_req[k] && $urandom_range(0, 2) == 0) new_inst(k);

    if (force_both) new_data(k);
    else if (data_req[k] && data_ack[k]) begin
      if ($urandom_range(0, 1) == 1) new_data(k);
      else data_req[k] = 1'b0;
    end else if (!data_req[k] && $urandom_range(0, 2) == 0) new_data(k);
  endtask

  task automatic sram_cycle(input int k);
    if (p_ce[k] && p_we[k])
      sram[k][p_addr[k][5:2]] = merge_bytes(sram[k][p_addr[k][5:2]], p_wdata[k], p_sel[k]);
    p_ce[k]    = ram_ce[k];
    p_we[k]    = ram_we[k];
    p_addr[k]  = ram_addr[k];
    p_sel[k]   = ram_sel[k];
    p_wdata[k] = ram_wdata[k];
  endtask

  // Asynchronous reset in the middle of an access.
  task automatic do_reset();
    #1;
    rst = 1'b0;
    for (int k = 0; k < NCFG; k++) clear_inputs(k);
    #1;
    for (int k = 0; k < NCFG; k++) check_zero(k, "arst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NCFG; k++) begin
      model_reset(k);
      // an abandoned store may already have reached the SRAM
      for (int w = 0; w < 16; w++) ref_mem[k][w] = sram[k][w];
    end
    $display("t=%0t async reset applied mid-access", $time);
  endtask

  initial begin
    bit force_next;
    int next_reset;
    rst = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      clear_inputs(k);
      model_reset(k);
      for (int w = 0; w < 16; w++) begin
        sram[k][w]    = $urandom();
        ref_mem[k][w] = sram[k][w];
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NCFG; k++) check_zero(k, "por");
    @(negedge clk);
    rst = 1'b1;
    force_next = 1'b1;
    next_reset = 800;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NCFG; k++) begin
        sram_cycle(k);
        check_regs(k);
      end
      for (int k = 0; k < NCFG; k++) drive(k, force_next);
      force_next = 1'b0;
      #1;
      for (int k = 0; k < NCFG; k++) begin
        check_val($sformatf("c%0d_pause_if", k), 32'(pause_if[k]),
                  32'(inst_req[k] && !e_iack[k]));
        check_val($sformatf("c%0d_pause_mem", k), 32'(pause_mem[k]),
                  32'(data_req[k] && !e_dack[k]));
        model_step(k);
      end
      if (cyc >= next_reset && ram_ce[0]) begin
        do_reset();
        force_next = 1'b1;
        next_reset = cyc + 1000;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported data/instruction SRAM between the fetch stage and the memory stage. Accepts word-aligned requests from both, grants one at a time with fair tie-breaking, and sequences a fixed-latency SRAM access. It returns read data with a one-cycle acknowledge and drives per-stage pause signals to the pipeline controller. Byte-lane extraction, sign extension and ALE detection stay in the memory stage; this block moves raw 32-bit words and byte selects.

## Interface
- ACCESS_CYCLES, 2, cycles the SRAM needs with ce held before rdata is valid; legal range 1..15
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- inst_req  in  1  fetch read request, held until inst_ack
- inst_addr  in  32  fetch word address, stable while inst_req
- inst_ack  out  1  one-cycle pulse, inst_rdata valid this cycle
- inst_rdata  out  32  fetched word
- flush  in  1  pipeline flush; cancels delivery of an in-flight fetch
- data_req  in  1  memory-stage request, held until data_ack
- data_we  in  1  1 = store, 0 = load
- data_addr  in  32  data address
- data_sel  in  4  byte enables, bit 3 = bits 31:24
- data_wdata  in  32  store word, already lane-replicated
- data_ack  out  1  one-cycle pulse; for loads data_rdata valid this cycle
- data_rdata  out  32  loaded word, raw
- pause_if  out  1  inst_req & ~inst_ack
- pause_mem  out  1  data_req & ~data_ack
- ram_ce, ram_we  out  1 each  SRAM chip enable / write enable
- ram_addr  out  32  SRAM address
- ram_sel  out  4  SRAM byte enables
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data

## Operation
- States: IDLE, BUSY. Registers: owner (INST/DATA), last_grant, 4-bit cnt, cancel flag, latched request, ack flops, rdata flops.
- Eligible requester in IDLE: req high and not being acked this cycle, so a held req is never granted twice.
- Arbitration in IDLE: one eligible requester -> grant it. Both eligible -> grant the one ≠ last_grant. last_grant updates on every grant.
- Grant: load ram_addr/ram_we/ram_sel/ram_wdata registers, set ram_ce=1, cnt=ACCESS_CYCLES-1, owner, state=BUSY. For fetch: ram_we=0, ram_sel=4'b1111, ram_wdata=0.
- BUSY: RAM outputs held constant. cnt decrements each cycle. When cnt==0: capture ram_rdata into owner's rdata, set owner's ack, and clear ram_ce/ram_we. Then state=IDLE.
- flush: if owner=INST in BUSY, or flush coincides with the fetch grant, set cancel. The access still runs to completion on the SRAM. inst_ack is suppressed and inst_rdata is not updated. Cancel clears on return to IDLE. flush never affects data accesses; stores are never aborted.
- flush in IDLE with no grant: no effect.
- pause_* are combinational from req and ack.
- Reset (async): state=IDLE, last_grant=INST (first tie goes to DATA), cancel=0. All outputs 0: ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, inst_ack, data_ack, inst_rdata, data_rdata. pause_* follow inputs. A reset mid-access abandons it with no ack.

## Timing
- Req sampled high in IDLE at cycle N -> ram_ce high cycles N+1..N+ACCESS_CYCLES -> ack high cycle N+ACCESS_CYCLES+1. Latency = ACCESS_CYCLES+1.
- The ack cycle is IDLE. The other requester may be granted in that cycle, so its RAM access starts at N+ACCESS_CYCLES+2.
- Same requester back-to-back: it drops or changes req after the ack. Minimum spacing between its grants is ACCESS_CYCLES+2 cycles.
- ack and rdata are registered. rdata holds until the next ack of the same port.
- ACCESS_CYCLES=1: ram_ce high for exactly one cycle per access.

## Test plan
- Single fetch, ACCESS_CYCLES=2: inst_req at cycle 0, addr 0x1C000000, ram_rdata=0x02C00421 -> ram_ce cycles 1-2, ram_sel=4'b1111. inst_ack only at cycle 3 with inst_rdata=0x02C00421. pause_if high cycles 0-2.
- Byte store: data_we=1, addr 0x80000003, sel 4'b0001, wdata 0xABABABAB -> ram_we=1, ram_sel=4'b0001 cycles 1-2. data_ack at cycle 3.
- Simultaneous reqs after reset, both held: grant order DATA, INST, DATA. data_ack at 3, inst_ack at 6. No duplicate grant during an ack cycle.
- flush at cycle 1 of an in-flight fetch: ram_ce still high cycles 1-2, no inst_ack. A pending data_req is granted at cycle 3. A refetch after flush completes normally.
- Async reset asserted mid-BUSY: all outputs 0 immediately, no ack after release. A fresh request after release completes with latency 3.
- ACCESS_CYCLES=1: load returns data_ack at cycle 2. Continuous fetch requests with data_req high throughout alternate grants, so neither requester starves.
